// File: rtl/seg_scan_pkg.sv
// Shared types and glyph constants for the seven-segment scan scheduler.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        PLAY = 2'd2
    } mode_t;

    typedef enum logic [3:0] {
        C_0, C_1, C_DASH, C_BLANK, C_r, C_E, C_C, C_P, C_L, C_A, C_Y
    } char_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] G_0     = 7'b1000000;
    localparam logic [6:0] G_1     = 7'b1111001;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_R     = 7'b0101111;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_C     = 7'b1000110;
    localparam logic [6:0] G_P     = 7'b0001100;
    localparam logic [6:0] G_L     = 7'b1000111;
    localparam logic [6:0] G_A     = 7'b0001000;
    localparam logic [6:0] G_Y     = 7'b0010001;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Character shown on a given digit (7 = leftmost) for a mode/slot pair.
    function automatic char_t msg_char(mode_t m, logic slot, logic [2:0] digit);
        char_t slot_c;
        slot_c = slot ? C_1 : C_0;
        msg_char = C_BLANK;
        case (m)
            REC: begin
                case (digit)
                    3'd7:    msg_char = C_r;
                    3'd6:    msg_char = C_E;
                    3'd5:    msg_char = C_C;
                    3'd0:    msg_char = slot_c;
                    default: msg_char = C_BLANK;
                endcase
            end
            PLAY: begin
                case (digit)
                    3'd7:    msg_char = C_P;
                    3'd6:    msg_char = C_L;
                    3'd5:    msg_char = C_A;
                    3'd4:    msg_char = C_Y;
                    3'd0:    msg_char = slot_c;
                    default: msg_char = C_BLANK;
                endcase
            end
            default: msg_char = (digit == 3'd0) ? C_DASH : C_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational character-code to active-low segment pattern lookup.
module seg_glyph_rom
    import seg_scan_pkg::*;
(
    input  char_t      code,
    output logic [6:0] seg
);

    always_comb begin
        seg = G_BLANK;
        case (code)
            C_0:     seg = G_0;
            C_1:     seg = G_1;
            C_DASH:  seg = G_DASH;
            C_BLANK: seg = G_BLANK;
            C_r:     seg = G_R;
            C_E:     seg = G_E;
            C_C:     seg = G_C;
            C_P:     seg = G_P;
            C_L:     seg = G_L;
            C_A:     seg = G_A;
            C_Y:     seg = G_Y;
            default: seg = G_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Eight-digit display scan controller: arbitrates record/playback per frame,
// scans digits with a leading blanking gap, registers all outputs.
module seg_scan_scheduler
    import seg_scan_pkg::*;
#(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 1000
)
(
    input  logic       clock,
    input  logic       reset,
    input  logic       rec_active,
    input  logic       play_active,
    input  logic       recordNum,
    input  logic       playNum,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic [1:0] mode,
    output logic       frame_tick
);

    localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;

    logic [CW-1:0] cnt_reg;
    logic [2:0]    idx_reg;
    mode_t         state_reg;
    logic          slot_reg;
    logic          run_reg;
    logic          boundary_reg;

    logic          last_tick;
    logic          frame_end;
    logic          blank;
    char_t         cur_char;
    logic [6:0]    glyph;
    logic [7:0]    an_dec;

    assign last_tick = (cnt_reg == CW'(DIGIT_TICKS - 1));
    assign frame_end = run_reg && last_tick && (idx_reg == 3'd7);
    assign blank     = (cnt_reg < CW'(BLANK_TICKS));
    assign cur_char  = msg_char(state_reg, slot_reg, idx_reg);

    seg_glyph_rom rom (
        .code (cur_char),
        .seg  (glyph)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_an
            assign an_dec[gi] = (idx_reg != 3'(gi));
        end
    endgenerate

    // run_reg keeps the counters parked for one extra cycle after reset so the
    // first post-reset cycle still shows reset values.
    always_ff @(posedge clock) begin
        if (reset) begin
            run_reg      <= 1'b0;
            cnt_reg      <= '0;
            idx_reg      <= 3'd0;
            state_reg    <= IDLE;
            slot_reg     <= 1'b0;
            boundary_reg <= 1'b0;
            an           <= AN_OFF;
            seg          <= SEG_OFF;
            mode         <= IDLE;
            frame_tick   <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (run_reg) begin
                if (last_tick) begin
                    cnt_reg <= '0;
                    idx_reg <= idx_reg + 3'd1;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
            if (frame_end) begin
                if (rec_active) begin
                    state_reg <= REC;
                    slot_reg  <= recordNum;
                end else if (play_active) begin
                    state_reg <= PLAY;
                    slot_reg  <= playNum;
                end else begin
                    state_reg <= IDLE;
                end
            end
            // frame_tick lines up with the cycle mode first shows the new frame
            boundary_reg <= frame_end;
            frame_tick   <= boundary_reg;
            an           <= blank ? AN_OFF : an_dec;
            seg          <= blank ? SEG_OFF : glyph;
            mode         <= state_reg;
        end
    end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Self-checking bench: directed scenarios plus random requests against a
// frame/slot-position reference model of the display.
module tb_seg_scan_scheduler;

    localparam int DT    = 8;
    localparam int BT    = 2;
    localparam int FRAME = 8 * DT;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rec_active = 1'b0;
    logic       play_active = 1'b0;
    logic       recordNum = 1'b0;
    logic       playNum = 1'b0;
    logic [7:0] an;
    logic [6:0] seg;
    logic [1:0] mode;
    logic       frame_tick;

    int tests = 0;
    int fails = 0;

    // Model state: e = cycle number since reset release (-1 in reset)
    int         e = -1;
    int         disp_m = 0;
    bit         disp_s = 1'b0;
    int         pend_m = 0;
    bit         pend_s = 1'b0;
    int         last_tick = -1;
    logic [7:0] run_an = 8'hFF;
    int         run_len = 0;

    seg_scan_scheduler #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
        .clock       (clock),
        .reset       (reset),
        .rec_active  (rec_active),
        .play_active (play_active),
        .recordNum   (recordNum),
        .playNum     (playNum),
        .an          (an),
        .seg         (seg),
        .mode        (mode),
        .frame_tick  (frame_tick)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] glyph_of(byte ch);
        case (ch)
            "0":     return 7'b1000000;
            "1":     return 7'b1111001;
            "-":     return 7'b0111111;
            "r":     return 7'b0101111;
            "E":     return 7'b0000110;
            "C":     return 7'b1000110;
            "P":     return 7'b0001100;
            "L":     return 7'b1000111;
            "A":     return 7'b0001000;
            "Y":     return 7'b0010001;
            default: return 7'b1111111;
        endcase
    endfunction

    // Message text written leftmost digit first.
    function automatic byte msg_ch(int m, bit s, int d);
        string t;
        case (m)
            1:       t = s ? "rEC____1" : "rEC____0";
            2:       t = s ? "PLAY___1" : "PLAY___0";
            default: t = "_______-";
        endcase
        return t[7 - d];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, e);
        end
    endtask

    task automatic step();
        bit         r  = reset;
        bit         ra = rec_active;
        bit         pa = play_active;
        bit         rn = recordNum;
        bit         pn = playNum;
        int         p;
        logic [7:0] xa;
        logic [6:0] xs;
        logic       xt;
        @(posedge clock);
        if (r) begin
            e = -1; disp_m = 0; disp_s = 0; pend_m = 0; pend_s = 0;
            last_tick = -1; run_an = 8'hFF; run_len = 0;
        end else begin
            e++;
            if (e > 1 && (e - 1) % FRAME == 0) begin
                disp_m = pend_m;
                disp_s = pend_s;
            end
            if (e > 0 && e % FRAME == 0) begin
                if (ra) begin
                    pend_m = 1; pend_s = rn;
                end else if (pa) begin
                    pend_m = 2; pend_s = pn;
                end else begin
                    pend_m = 0;
                end
            end
        end
        xa = 8'hFF; xs = 7'h7F; xt = 1'b0;
        if (e >= 1) begin
            p = (e - 1) % FRAME;
            if (p % DT >= BT) begin
                xa = ~(8'd1 << (p / DT));
                xs = glyph_of(msg_ch(disp_m, disp_s, p / DT));
            end
            xt = (p == 0 && e > 1);
        end
        #1;
        check("an", an, xa);
        check("seg", seg, xs);
        check("mode", mode, disp_m);
        check("frame_tick", frame_tick, xt);
        check("one_anode", ($countones(~an) <= 1), 1);
        if (an == run_an && an != 8'hFF) begin
            run_len++;
        end else begin
            if (run_an != 8'hFF) check("low_run", run_len, DT - BT);
            run_an  = an;
            run_len = 1;
        end
        if (frame_tick === 1'b1) begin
            if (last_tick >= 0) check("tick_gap", e - last_tick, FRAME);
            last_tick = e;
        end
    endtask

    initial begin
        // Idle after reset, with a short record pulse inside the first frame
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        while (e < 130) begin
            rec_active = (e >= 19 && e < 30);
            step();
            if (e == 2)  check("idle_blank_an", an, 8'hFF);
            if (e == 3)  check("idle_d0_an", an, 8'hFE);
            if (e == 3)  check("idle_d0_seg", seg, 7'b0111111);
            if (e == 8)  check("idle_d0_end", an, 8'hFE);
            if (e == 64) check("idle_no_tick", frame_tick, 1'b0);
            if (e == 65) check("idle_tick", frame_tick, 1'b1);
            if (e == 65) check("pulse_ignored", mode, 2'd0);
            if (e == 125) check("idle_d7_seg", seg, 7'h7F);
        end

        // Record slot 1 held from cycle 10
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        recordNum = 1'b1;
        while (e < 140) begin
            rec_active = (e >= 9);
            step();
            if (e == 64)  check("rec_mode_pre", mode, 2'd0);
            if (e == 65)  check("rec_mode", mode, 2'd1);
            if (e == 68)  check("rec_d0_seg", seg, 7'b1111001);
            if (e == 77)  check("rec_d1_seg", seg, 7'b1111111);
            if (e == 125) check("rec_d7_seg", seg, 7'b0101111);
            if (e == 125) check("rec_d7_an", an, 8'h7F);
        end

        // Playback slot 0, record raised mid-frame preempts at next boundary
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        rec_active = 1'b0; recordNum = 1'b0;
        play_active = 1'b1; playNum = 1'b0;
        while (e < 200) begin
            rec_active = (e >= 90);
            step();
            if (e == 68)  check("play_d0_seg", seg, 7'b1000000);
            if (e == 100) check("play_mode", mode, 2'd2);
            if (e == 125) check("play_d7_seg", seg, 7'b0001100);
            if (e == 128) check("play_intact", mode, 2'd2);
            if (e == 129) check("preempt_mode", mode, 2'd1);
            if (e == 189) check("preempt_d7_seg", seg, 7'b0101111);
        end

        // One-cycle reset at cycle 40 of a record frame
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        play_active = 1'b0;
        rec_active = 1'b1;
        while (e < 104) step();
        check("pre_reset_mode", mode, 2'd1);
        reset = 1'b1;
        step();
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_mode", mode, 2'd0);
        reset = 1'b0;
        rec_active = 1'b0;
        while (e < 3) step();
        check("rst_restart_an", an, 8'hFE);
        while (e < 70) step();

        // Random requests
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 31) == 0) rec_active = ~rec_active;
            if ($urandom_range(0, 31) == 0) play_active = ~play_active;
            recordNum = 1'($urandom_range(0, 1));
            playNum   = 1'($urandom_range(0, 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
